// File: rtl/time_setup_unit.sv
// time_setup_unit
// Multi-field time editor that sits between the debounced setup buttons and
// the timekeeping counter. Entering setup mode snapshots the running time;
// select/inc/dec edit one field at a time with per-field wrap-around and
// press-and-hold auto-repeat; confirm issues a one-cycle load pulse.
module time_setup_unit #(
  parameter int          NUM_FIELDS   = 3,
  parameter int          FIELD_W      = 8,
  parameter logic [31:0] FIELD_MODS   = {8'd0, 8'd24, 8'd60, 8'd60},
  parameter int          REPEAT_DELAY = 50_000_000,
  parameter int          REPEAT_RATE  = 10_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mode_setup,
  input  logic                          btn_sel,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          btn_ok,
  input  logic [NUM_FIELDS*FIELD_W-1:0] load_data,
  output logic [NUM_FIELDS*FIELD_W-1:0] setup_data,
  output logic                          setup_imp,
  output logic [1:0]                    field_sel,
  output logic                          editing
);

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EDIT = 1'b1;

  // Modulus values need one extra bit so a full 2^FIELD_W range fits.
  localparam int MW = FIELD_W + 1;

  // Hold counter only ever needs to reach the larger of the two intervals.
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(REP_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);
  localparam logic [1:0]       LAST_SEL = 2'(NUM_FIELDS - 1);

  // Modulus of field idx; a zero byte stands for the full 2^FIELD_W range.
  function automatic logic [MW-1:0] field_mod(input int idx);
    logic [7:0] b;
    b = FIELD_MODS[idx*8 +: 8];
    if (b == 8'd0) begin
      field_mod = {1'b1, {FIELD_W{1'b0}}};
    end else begin
      field_mod = MW'(b);
    end
  endfunction

  // Increment with wrap at the field modulus.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                  input logic [MW-1:0]      m);
    if ({1'b0, v} >= (m - MW'(1))) begin
      wrap_inc = {FIELD_W{1'b0}};
    end else begin
      wrap_inc = v + FIELD_W'(1);
    end
  endfunction

  // Decrement with wrap from zero to modulus-1.
  function automatic logic [FIELD_W-1:0] wrap_dec(input logic [FIELD_W-1:0] v,
                                                  input logic [MW-1:0]      m);
    if ((v == {FIELD_W{1'b0}}) || ({1'b0, v} >= m)) begin
      wrap_dec = FIELD_W'(m - MW'(1));
    end else begin
      wrap_dec = v - FIELD_W'(1);
    end
  endfunction

  // Registers
  logic [0:0]                    state_q, state_d;
  logic [NUM_FIELDS*FIELD_W-1:0] data_q, data_d;
  logic                          imp_q, imp_d;
  logic [1:0]                    fsel_q, fsel_d;
  logic                          editing_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          rep_q, rep_d;   // in the periodic repeat phase
  logic                          blk_q, blk_d;   // hold ignored until a new rise
  logic                          mode_q, sel_q, inc_q, dec_q, ok_q;

  // Combinational helpers
  logic                          mode_rise_s, sel_press_s, ok_press_s;
  logic                          inc_press_s, dec_press_s;
  logic                          inc_only_s, dec_only_s, active_rise_s;
  logic [CNT_W-1:0]              cnt_nxt_s;
  logic                          load_en_s, step_s, step_up_s;
  logic [NUM_FIELDS*FIELD_W-1:0] loaded_s;

  assign mode_rise_s   = mode_setup & ~mode_q;
  assign sel_press_s   = btn_sel & ~sel_q;
  assign ok_press_s    = btn_ok  & ~ok_q;
  assign inc_press_s   = btn_inc & ~inc_q;
  assign dec_press_s   = btn_dec & ~dec_q;
  assign inc_only_s    = btn_inc & ~btn_dec;
  assign dec_only_s    = btn_dec & ~btn_inc;
  assign active_rise_s = (inc_only_s & inc_press_s) | (dec_only_s & dec_press_s);
  assign cnt_nxt_s     = cnt_q + CNT_W'(1);

  // Snapshot of load_data with out-of-range fields forced to zero.
  always_comb begin
    loaded_s = load_data;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if ({1'b0, load_data[i*FIELD_W +: FIELD_W]} >= field_mod(i)) begin
        loaded_s[i*FIELD_W +: FIELD_W] = {FIELD_W{1'b0}};
      end else begin
        loaded_s[i*FIELD_W +: FIELD_W] = load_data[i*FIELD_W +: FIELD_W];
      end
    end
  end

  // FSM control: state transitions, commit pulse, field select, auto-repeat.
  always_comb begin
    state_d   = state_q;
    imp_d     = 1'b0;
    fsel_d    = fsel_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    blk_d     = blk_q;
    load_en_s = 1'b0;
    step_s    = 1'b0;
    step_up_s = inc_only_s;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        rep_d = 1'b0;
        blk_d = 1'b0;
        if (mode_rise_s) begin
          state_d   = ST_EDIT;
          load_en_s = 1'b1;
          fsel_d    = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EDIT: begin
        if (!mode_setup) begin
          // Abort: leave edited value on setup_data, no commit.
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          rep_d   = 1'b0;
          blk_d   = 1'b0;
        end else if (ok_press_s) begin
          state_d = ST_IDLE;
          imp_d   = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          rep_d   = 1'b0;
          blk_d   = 1'b0;
        end else if (sel_press_s) begin
          fsel_d = (fsel_q >= LAST_SEL) ? 2'd0 : (fsel_q + 2'd1);
          cnt_d  = {CNT_W{1'b0}};
          rep_d  = 1'b0;
          // A button still held across the field change must be re-pressed.
          blk_d  = btn_inc | btn_dec;
        end else if (inc_only_s || dec_only_s) begin
          if (active_rise_s) begin
            step_s = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
            rep_d  = 1'b0;
            blk_d  = 1'b0;
          end else if (blk_q) begin
            cnt_d = {CNT_W{1'b0}};
            rep_d = 1'b0;
          end else if (!rep_q && (cnt_nxt_s == DELAY_C)) begin
            step_s = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
            rep_d  = 1'b1;
          end else if (rep_q && (cnt_nxt_s == RATE_C)) begin
            step_s = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_nxt_s;
          end
        end else if (btn_inc && btn_dec) begin
          // Conflicting buttons: no step, counter parked at zero.
          cnt_d = {CNT_W{1'b0}};
          rep_d = 1'b0;
        end else begin
          // Released: clear the hold state entirely.
          cnt_d = {CNT_W{1'b0}};
          rep_d = 1'b0;
          blk_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        rep_d   = 1'b0;
        blk_d   = 1'b0;
      end
    endcase
  end

  // Edited value: snapshot on entry, otherwise step only the selected field.
  always_comb begin
    data_d = data_q;
    if (load_en_s) begin
      data_d = loaded_s;
    end else if (step_s) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (fsel_q == 2'(i)) begin
          if (step_up_s) begin
            data_d[i*FIELD_W +: FIELD_W] = wrap_inc(data_q[i*FIELD_W +: FIELD_W], field_mod(i));
          end else begin
            data_d[i*FIELD_W +: FIELD_W] = wrap_dec(data_q[i*FIELD_W +: FIELD_W], field_mod(i));
          end
        end else begin
          data_d[i*FIELD_W +: FIELD_W] = data_q[i*FIELD_W +: FIELD_W];
        end
      end
    end else begin
      data_d = data_q;
    end
  end

  // State, datapath and button history registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= {(NUM_FIELDS*FIELD_W){1'b0}};
      imp_q     <= 1'b0;
      fsel_q    <= 2'd0;
      editing_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      rep_q     <= 1'b0;
      blk_q     <= 1'b0;
      mode_q    <= 1'b0;
      sel_q     <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      imp_q     <= imp_d;
      fsel_q    <= fsel_d;
      editing_q <= (state_d == ST_EDIT);
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      blk_q     <= blk_d;
      mode_q    <= mode_setup;
      sel_q     <= btn_sel;
      inc_q     <= btn_inc;
      dec_q     <= btn_dec;
      ok_q      <= btn_ok;
    end
  end

  assign setup_data = data_q;
  assign setup_imp  = imp_q;
  assign field_sel  = fsel_q;
  assign editing    = editing_q;

endmodule

// File: tb/tb_time_setup_unit.sv
// Directed, table-driven bench for time_setup_unit (3 fields h/m/s,
// short repeat intervals so auto-repeat is observable).
module tb_time_setup_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mode_setup, btn_sel, btn_inc, btn_dec, btn_ok;
  logic [23:0] load_data;
  logic [23:0] setup_data;
  logic        setup_imp;
  logic [1:0]  field_sel;
  logic        editing;

  int n_cmp  = 0;
  int n_fail = 0;

  time_setup_unit #(
    .NUM_FIELDS  (3),
    .FIELD_W     (8),
    .FIELD_MODS  ({8'd0, 8'd24, 8'd60, 8'd60}),
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mode_setup(mode_setup),
    .btn_sel   (btn_sel),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .btn_ok    (btn_ok),
    .load_data (load_data),
    .setup_data(setup_data),
    .setup_imp (setup_imp),
    .field_sel (field_sel),
    .editing   (editing)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mode, sel, inc, dec, ok;
    logic [23:0] load;
    logic [23:0] data;
    logic        imp;
    logic [1:0]  fsel;
    logic        edit;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  function automatic vec_t mk(input logic mode, input logic sel, input logic inc,
                              input logic dec, input logic ok, input logic [23:0] load,
                              input logic [23:0] data, input logic imp,
                              input logic [1:0] fsel, input logic edit);
    vec_t v;
    v.mode = mode; v.sel = sel; v.inc = inc; v.dec = dec; v.ok = ok;
    v.load = load; v.data = data; v.imp = imp; v.fsel = fsel; v.edit = edit;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic mode, input logic sel, input logic inc,
                       input logic dec, input logic ok);
    mode_setup = mode; btn_sel = sel; btn_inc = inc; btn_dec = dec; btn_ok = ok;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [23:0] d, input logic imp,
                         input logic [1:0] fs, input logic ed);
    chk({nm, " data"}, 32'(setup_data), 32'(d));
    chk({nm, " imp"},  32'(setup_imp),  32'(imp));
    chk({nm, " fsel"}, 32'(field_sel),  32'(fs));
    chk({nm, " edit"}, 32'(editing),    32'(ed));
  endtask

  initial begin
    // mode sel inc dec ok | load | expected data imp fsel edit
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,56), 0, 0, 1)); // 0 entry
    tbl.push_back(mk(1,0,1,0,0, hms(12,34,56), hms(12,34,57), 0, 0, 1));
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,57), 0, 0, 1));
    tbl.push_back(mk(1,0,1,0,0, hms(12,34,56), hms(12,34,58), 0, 0, 1));
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,58), 0, 0, 1));
    tbl.push_back(mk(1,0,1,0,0, hms(12,34,56), hms(12,34,59), 0, 0, 1)); // 5
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,59), 0, 0, 1));
    tbl.push_back(mk(1,0,1,0,0, hms(12,34,56), hms(12,34,0),  0, 0, 1)); // inc wrap
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,0),  0, 0, 1));
    tbl.push_back(mk(1,0,0,1,0, hms(12,34,56), hms(12,34,59), 0, 0, 1)); // dec wrap
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,59), 0, 0, 1)); // 10
    tbl.push_back(mk(1,1,0,0,0, hms(12,34,56), hms(12,34,59), 0, 1, 1));
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,59), 0, 1, 1));
    tbl.push_back(mk(1,1,0,0,0, hms(12,34,56), hms(12,34,59), 0, 2, 1));
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(12,34,59), 0, 2, 1));
    tbl.push_back(mk(1,0,0,1,0, hms(12,34,56), hms(11,34,59), 0, 2, 1)); // 15
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(11,34,59), 0, 2, 1));
    tbl.push_back(mk(1,1,0,0,0, hms(12,34,56), hms(11,34,59), 0, 0, 1)); // sel wrap
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(11,34,59), 0, 0, 1));
    tbl.push_back(mk(1,0,1,1,0, hms(12,34,56), hms(11,34,59), 0, 0, 1)); // inc+dec
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(11,34,59), 0, 0, 1)); // 20
    tbl.push_back(mk(1,1,0,0,1, hms(12,34,56), hms(11,34,59), 1, 0, 0)); // ok+sel
    tbl.push_back(mk(1,0,0,0,0, hms(12,34,56), hms(11,34,59), 0, 0, 0));
    tbl.push_back(mk(0,0,1,0,0, hms(12,34,56), hms(11,34,59), 0, 0, 0)); // idle ignores inc
    tbl.push_back(mk(1,0,0,0,0, hms(12,6,56),  hms(12,6,56),  0, 0, 1)); // re-entry
    tbl.push_back(mk(1,1,0,0,0, hms(12,6,56),  hms(12,6,56),  0, 1, 1)); // 25
    tbl.push_back(mk(1,0,0,0,0, hms(12,6,56),  hms(12,6,56),  0, 1, 1));
    tbl.push_back(mk(1,0,1,0,0, hms(12,6,56),  hms(12,7,56),  0, 1, 1));
    tbl.push_back(mk(1,0,0,0,0, hms(12,6,56),  hms(12,7,56),  0, 1, 1));
    tbl.push_back(mk(0,0,0,0,0, hms(12,6,56),  hms(12,7,56),  0, 1, 0)); // abort keeps 7
    tbl.push_back(mk(1,0,0,0,0, hms(1,2,3),    hms(1,2,3),    0, 0, 1)); // 30 reload
    tbl.push_back(mk(0,0,0,0,0, hms(1,2,3),    hms(1,2,3),    0, 0, 0));
    tbl.push_back(mk(1,0,0,0,0, hms(0,5,75),   hms(0,5,0),    0, 0, 1)); // 75 -> 0
    tbl.push_back(mk(1,1,0,0,0, hms(0,5,75),   hms(0,5,0),    0, 1, 1));
    tbl.push_back(mk(1,0,0,0,0, hms(0,5,75),   hms(0,5,0),    0, 1, 1));
    tbl.push_back(mk(1,1,0,0,0, hms(0,5,75),   hms(0,5,0),    0, 2, 1)); // 35
    tbl.push_back(mk(1,0,0,0,0, hms(0,5,75),   hms(0,5,0),    0, 2, 1));
    tbl.push_back(mk(1,0,0,1,0, hms(0,5,75),   hms(23,5,0),   0, 2, 1)); // hours 0 -> 23
    tbl.push_back(mk(1,0,0,0,0, hms(0,5,75),   hms(23,5,0),   0, 2, 1));

    // Reset
    reset = 1'b1;
    load_data = 24'h000000;
    drive(0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk_all("reset", 24'h000000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    cyc();
    chk_all("post-reset idle", 24'h000000, 1'b0, 2'd0, 1'b0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mode, tbl[i].sel, tbl[i].inc, tbl[i].dec, tbl[i].ok);
      load_data = tbl[i].load;
      cyc();
      chk_all($sformatf("vec%0d", i), tbl[i].data, tbl[i].imp, tbl[i].fsel, tbl[i].edit);
    end

    // Back to field 0 (value 0)
    drive(1, 1, 0, 0, 0); cyc();
    drive(1, 0, 0, 0, 0); cyc();
    chk_all("sel to f0", hms(23,5,0), 1'b0, 2'd0, 1'b1);

    // Hold inc 11 sampled edges: steps at press, +4, +6, +8, +10
    begin
      int exp_s [11] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
      for (int k = 0; k < 11; k++) begin
        drive(1, 0, 1, 0, 0);
        cyc();
        chk($sformatf("hold%0d f0", k), 32'(setup_data[7:0]), 32'(exp_s[k]));
      end
    end
    chk("hold other fields", 32'(setup_data[23:8]), 32'({8'd23, 8'd5}));
    drive(1, 0, 0, 0, 0); cyc();

    // Second hold after release: counter restarts from the new press
    begin
      int exp_r [5] = '{6, 6, 6, 6, 7};
      for (int k = 0; k < 5; k++) begin
        drive(1, 0, 1, 0, 0);
        cyc();
        chk($sformatf("rehold%0d f0", k), 32'(setup_data[7:0]), 32'(exp_r[k]));
      end
    end
    drive(1, 0, 0, 0, 0); cyc();

    // sel mid-hold: no further steps without a fresh rise
    drive(1, 0, 1, 0, 0); cyc();
    chk("midsel press", 32'(setup_data), 32'(hms(23,5,8)));
    cyc(); cyc();
    drive(1, 1, 1, 0, 0); cyc();
    chk("midsel fsel", 32'(field_sel), 32'd1);
    drive(1, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) cyc();
    chk_all("midsel blocked", hms(23,5,8), 1'b0, 2'd1, 1'b1);
    drive(1, 0, 0, 0, 0); cyc();

    // Reset mid-hold on field 1
    drive(1, 0, 1, 0, 0); cyc();
    chk("prereset step", 32'(setup_data), 32'(hms(23,6,8)));
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk_all("reset midhold", 24'h000000, 1'b0, 2'd0, 1'b0);
    drive(0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk_all("after reset", 24'h000000, 1'b0, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
